// File: rtl/aes_seq_pkg.sv
// Shared state encoding, widths and scan-chain layout for the AES trace sequencer.
package aes_seq_pkg;

    localparam int unsigned AES_PT_W   = 128;
    localparam int unsigned AES_KEY_W  = 256;
    localparam int unsigned AES_SC_W   = 387;

    localparam int unsigned SC_PT_LSB  = 259;
    localparam int unsigned SC_KEY_LSB = 3;
    localparam int unsigned SC_PT_SEL  = 2;
    localparam int unsigned SC_KEY_SEL = 1;
    localparam int unsigned SC_CT_SEL  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RUN,
        ST_DRAIN,
        ST_RESP
    } seq_state_e;

    typedef struct packed {
        logic [AES_PT_W-1:0]  pt;
        logic [AES_KEY_W-1:0] key;
        logic                 pt_sel;
        logic                 key_sel;
        logic                 ct_out_sel;
    } aes_job_t;

    // Place job fields at their aes_if scan-chain offsets.
    function automatic logic [AES_SC_W-1:0] sc_pack(input aes_job_t job);
        logic [AES_SC_W-1:0] sc;
        sc = '0;
        sc[SC_PT_LSB +: AES_PT_W]   = job.pt;
        sc[SC_KEY_LSB +: AES_KEY_W] = job.key;
        sc[SC_PT_SEL]               = job.pt_sel;
        sc[SC_KEY_SEL]              = job.key_sel;
        sc[SC_CT_SEL]               = job.ct_out_sel;
        return sc;
    endfunction

endpackage

// File: rtl/aes_seq_wdog.sv
// RUN-state watchdog: cleared on RUN entry, counts enabled cycles, flags the LIMIT-th one.
module aes_seq_wdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire_c
);
    localparam int unsigned CNT_W = $clog2(LIMIT) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire_c = en && (cnt_q == CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expire_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aes_trace_seq.sv
// Job sequencer for aes_if: holds the scan chain, pulses aes_enable per repetition, returns
// one captured ciphertext per repetition. Optional RUN watchdog: `define AES_SEQ_TIMEOUT_EN.
module aes_trace_seq
    import aes_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned REP_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [AES_PT_W-1:0]  req_pt,
    input  logic [AES_KEY_W-1:0] req_key,
    input  logic                 req_pt_sel,
    input  logic                 req_key_sel,
    input  logic                 req_ct_out_sel,
    input  logic [REP_W-1:0]     req_reps,
    output logic [AES_SC_W-1:0]  aes_scan_chain,
    output logic                 aes_enable,
    input  logic                 aes_trigger,
    input  logic [AES_SC_W-1:0]  aes_sc_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [AES_PT_W-1:0]  rsp_ct,
    output logic [REP_W-1:0]     rsp_idx,
    output logic                 rsp_last,
    output logic                 rsp_timeout,
    output logic                 busy
);
    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1) + 1;

    seq_state_e           state_q, state_d;
    logic [SETTLE_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [REP_W-1:0]     idx_q, idx_d;
    logic [REP_W-1:0]     reps_m1_q, reps_m1_d;
    logic [AES_SC_W-1:0]  sc_q, sc_d;
    logic [AES_PT_W-1:0]  rsp_ct_q, rsp_ct_d;
    logic                 rsp_last_q, rsp_last_d;
    logic                 rsp_timeout_q, rsp_timeout_d;
    logic                 req_ready_q, aes_enable_q, rsp_valid_q, busy_q;
    logic                 trig_q;
    logic                 trig_rise_c;
    logic                 run_entry_c;
    logic                 wdog_expire_c;
    logic                 unused_sc_c;
    aes_job_t             req_job_c;

    assign req_job_c = '{pt: req_pt, key: req_key, pt_sel: req_pt_sel,
                         key_sel: req_key_sel, ct_out_sel: req_ct_out_sel};

    // A trigger already high when RUN is entered has trig_q set and never counts as a rise.
    assign trig_rise_c = aes_trigger & ~trig_q;
    assign unused_sc_c = ^aes_sc_out[AES_SC_W-1:AES_PT_W];

`ifdef AES_SEQ_TIMEOUT_EN
    aes_seq_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (run_entry_c),
        .en       (state_q == ST_RUN),
        .expire_c (wdog_expire_c)
    );
`else
    logic unused_cfg_c;
    assign unused_cfg_c  = run_entry_c ^ (^32'(TIMEOUT_CYCLES));
    assign wdog_expire_c = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        idx_d         = idx_q;
        reps_m1_d     = reps_m1_q;
        sc_d          = sc_q;
        rsp_ct_d      = rsp_ct_q;
        rsp_last_d    = rsp_last_q;
        rsp_timeout_d = rsp_timeout_q;
        run_entry_c   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    sc_d         = sc_pack(req_job_c);
                    reps_m1_d    = (req_reps == '0) ? '0 : req_reps - REP_W'(1);
                    idx_d        = '0;
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                // Held one extra cycle so enable lands SETTLE_CYCLES edges after the chain is valid.
                if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES)) begin
                    state_d     = ST_RUN;
                    run_entry_c = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                end
            end
            ST_RUN: begin
                if (trig_rise_c) begin
                    rsp_ct_d = aes_sc_out[AES_PT_W-1:0];
                    state_d  = ST_DRAIN;
                end else if (wdog_expire_c) begin
                    rsp_ct_d      = '0;
                    rsp_last_d    = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end
            end
            ST_DRAIN: begin
                if (!aes_trigger) begin
                    rsp_last_d    = (idx_q == reps_m1_q);
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_last_d    = 1'b0;
                    rsp_timeout_d = 1'b0;
                    if (rsp_last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d       = idx_q + REP_W'(1);
                        state_d     = ST_RUN;
                        run_entry_c = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they change on the transition edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            settle_cnt_q  <= '0;
            idx_q         <= '0;
            reps_m1_q     <= '0;
            sc_q          <= '0;
            rsp_ct_q      <= '0;
            rsp_last_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
            req_ready_q   <= 1'b0;
            aes_enable_q  <= 1'b0;
            rsp_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            trig_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            idx_q         <= idx_d;
            reps_m1_q     <= reps_m1_d;
            sc_q          <= sc_d;
            rsp_ct_q      <= rsp_ct_d;
            rsp_last_q    <= rsp_last_d;
            rsp_timeout_q <= rsp_timeout_d;
            req_ready_q   <= (state_d == ST_IDLE);
            aes_enable_q  <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            rsp_valid_q   <= (state_d == ST_RESP);
            busy_q        <= (state_d != ST_IDLE);
            trig_q        <= aes_trigger;
        end
    end

    assign req_ready      = req_ready_q;
    assign aes_scan_chain = sc_q;
    assign aes_enable     = aes_enable_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_ct         = rsp_ct_q;
    assign rsp_idx        = idx_q;
    assign rsp_last       = rsp_last_q;
    assign rsp_timeout    = rsp_timeout_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_aes_trace_seq.sv
// Directed bench for aes_trace_seq with a small aes_if trigger model.
module tb_aes_trace_seq;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned REP_W  = 8;
    localparam int unsigned TMO    = 16;
    localparam int unsigned SCW    = 387;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [127:0]       req_pt;
    logic [255:0]       req_key;
    logic               req_pt_sel;
    logic               req_key_sel;
    logic               req_ct_out_sel;
    logic [REP_W-1:0]   req_reps;
    logic [SCW-1:0]     aes_scan_chain;
    logic               aes_enable;
    logic               aes_trigger;
    logic [SCW-1:0]     aes_sc_out;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [127:0]       rsp_ct;
    logic [REP_W-1:0]   rsp_idx;
    logic               rsp_last;
    logic               rsp_timeout;
    logic               busy;

    aes_trace_seq #(
        .SETTLE_CYCLES  (SETTLE),
        .REP_W          (REP_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_pt         (req_pt),
        .req_key        (req_key),
        .req_pt_sel     (req_pt_sel),
        .req_key_sel    (req_key_sel),
        .req_ct_out_sel (req_ct_out_sel),
        .req_reps       (req_reps),
        .aes_scan_chain (aes_scan_chain),
        .aes_enable     (aes_enable),
        .aes_trigger    (aes_trigger),
        .aes_sc_out     (aes_sc_out),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_ct         (rsp_ct),
        .rsp_idx        (rsp_idx),
        .rsp_last       (rsp_last),
        .rsp_timeout    (rsp_timeout),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0]     pt;
        logic [255:0]     key;
        logic             pt_sel;
        logic             key_sel;
        logic             ct_sel;
        logic [REP_W-1:0] reps;
        int               stall;
        int               mode;   // 0 normal, 1 never, 2 stale-high, 3 trigger on RUN cycle 16
        logic [127:0]     ct_base;
        int               exp_n;
        logic             exp_to;
    } vec_t;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           model_mode = 0;
    logic [127:0] model_ct = '0;
    int           en_cnt;
    int           en_run_len;
    int           en_pulses;
    int           model_rep;
    logic         en_prev;
    logic         stale;

    task automatic chk(input string name, input logic [SCW-1:0] act, input logic [SCW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [127:0] pt, input logic [255:0] key, input logic [2:0] sel,
                                input int reps, input int stall, input int mode,
                                input logic [127:0] ct, input int exp_n, input logic exp_to);
        vec_t v;
        v.pt = pt; v.key = key;
        v.pt_sel = sel[2]; v.key_sel = sel[1]; v.ct_sel = sel[0];
        v.reps = REP_W'(reps); v.stall = stall; v.mode = mode;
        v.ct_base = ct; v.exp_n = exp_n; v.exp_to = exp_to;
        return v;
    endfunction

    // aes_if model: trigger pattern keyed on cycles since aes_enable rose, ciphertext per pulse.
    initial begin
        aes_trigger = 1'b0;
        aes_sc_out  = '0;
        en_cnt = 0; en_run_len = 0; en_pulses = 0; model_rep = 0; en_prev = 1'b0; stale = 1'b0;
        forever begin
            @(negedge clk);
            if (aes_enable) begin
                en_cnt++;
            end else begin
                if (en_prev) begin
                    en_run_len = en_cnt;
                    model_rep++;
                end
                en_cnt = 0;
            end
            if (aes_enable && !en_prev) en_pulses++;
            en_prev = aes_enable;
            stale = (model_mode == 2) && (en_cnt <= 3);
            case (model_mode)
                1:       aes_trigger = 1'b0;
                2:       aes_trigger = stale || (en_cnt >= 6 && en_cnt <= 8);
                3:       aes_trigger = (en_cnt == 16);
                default: aes_trigger = (en_cnt >= 6 && en_cnt <= 8);
            endcase
            aes_sc_out = {{(SCW-128){1'b1}}, stale ? ~model_ct : model_ct + 128'(model_rep)};
        end
    end

    task automatic run_job(input vec_t v, input string tag);
        int             n_edges;
        int             got;
        int             wait_n;
        int             rep_base;
        int             pulse_base;
        logic           extra;
        logic [SCW-1:0] exp_sc;
        logic [127:0]   exp_ct;
        model_mode = v.mode;
        rep_base   = model_rep;
        pulse_base = en_pulses;
        model_ct   = v.ct_base - 128'(rep_base);
        rsp_ready  = (v.stall == 0);
        exp_sc     = {v.pt, v.key, v.pt_sel, v.key_sel, v.ct_sel};
        wait_n = 0;
        while (!req_ready && wait_n < 50) begin tick(); wait_n++; end
        chk({tag, "_req_ready"}, SCW'(req_ready), SCW'(1));
        req_pt = v.pt; req_key = v.key; req_pt_sel = v.pt_sel; req_key_sel = v.key_sel;
        req_ct_out_sel = v.ct_sel; req_reps = v.reps; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk({tag, "_accept"}, SCW'({req_ready, busy}), SCW'(2'b01));
        chk({tag, "_scan"}, aes_scan_chain, exp_sc);
        n_edges = 0;
        while (!aes_enable && n_edges < 50) begin tick(); n_edges++; end
        chk({tag, "_en_latency"}, SCW'(n_edges), SCW'(1 + SETTLE));
        got = 0;
        while (got < v.exp_n) begin
            wait_n = 0;
            while (!rsp_valid && wait_n < 300) begin tick(); wait_n++; end
            if (!rsp_valid) begin
                chk({tag, "_rsp_wait"}, SCW'(rsp_valid), SCW'(1));
                break;
            end
            exp_ct = v.exp_to ? 128'h0 : v.ct_base + 128'(got);
            chk({tag, "_ct"}, SCW'(rsp_ct), SCW'(exp_ct));
            chk({tag, "_idx"}, SCW'(rsp_idx), SCW'(got));
            chk({tag, "_last"}, SCW'(rsp_last), SCW'(got == v.exp_n - 1));
            chk({tag, "_timeout"}, SCW'(rsp_timeout), SCW'(v.exp_to));
            chk({tag, "_en_in_resp"}, SCW'(aes_enable), SCW'(0));
            for (int s = 0; s < v.stall; s++) begin
                tick();
                chk({tag, "_stall"}, SCW'({aes_enable, rsp_valid, rsp_idx, rsp_ct}),
                    SCW'({1'b0, 1'b1, REP_W'(got), exp_ct}));
            end
            rsp_ready = 1'b1;
            tick();
            chk({tag, "_valid_drop"}, SCW'(rsp_valid), SCW'(0));
            if (got == v.exp_n - 1) chk({tag, "_req_ready_back"}, SCW'(req_ready), SCW'(1));
            if (v.stall != 0) rsp_ready = 1'b0;
            got++;
        end
        rsp_ready = 1'b0;
        extra = 1'b0;
        repeat (12) begin
            tick();
            if (rsp_valid || aes_enable) extra = 1'b1;
        end
        chk({tag, "_no_extra"}, SCW'(extra), SCW'(0));
        chk({tag, "_pulses"}, SCW'(en_pulses - pulse_base), SCW'(v.exp_n));
        chk({tag, "_scan_hold"}, aes_scan_chain, exp_sc);
        if (v.mode == 1) chk({tag, "_run_len"}, SCW'(en_run_len), SCW'(TMO));
    endtask

    vec_t vecs[4];
    vec_t vj;
    int   wn;
    logic seen;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_pt = '0; req_key = '0; req_pt_sel = 1'b0; req_key_sel = 1'b0;
        req_ct_out_sel = 1'b0; req_reps = '0;

        vecs[0] = mk(128'h00112233445566778899aabbccddeeff, 256'h0, 3'b110, 1, 0, 0,
                     128'h1c060f4c9e7ea8d6ca961a2d64c05c18, 1, 1'b0);
        vecs[1] = mk(128'hdeadbeef_01234567_89abcdef_cafef00d, {8{32'ha5a55a5a}}, 3'b011, 4, 6, 0,
                     128'h0f0e0d0c_0b0a0908_07060504_030201fe, 4, 1'b0);
        vecs[2] = mk(128'h11111111_22222222_33333333_44444444, {4{64'h0123456789abcdef}}, 3'b101, 0, 0, 2,
                     128'h55aa55aa_00ff00ff_12345678_9abcdef0, 1, 1'b0);
        vecs[3] = mk(128'hffffffff_ffffffff_ffffffff_ffffffff, 256'h1, 3'b000, 3, 0, 0,
                     128'h80000000_00000000_00000000_ffffffff, 3, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", SCW'({req_ready, aes_enable, rsp_valid, rsp_last, rsp_timeout, busy}), SCW'(0));
        chk("rst_scan", aes_scan_chain, SCW'(0));
        chk("rst_rsp", SCW'({rsp_ct, rsp_idx}), SCW'(0));
        rst_n = 1'b1;
        tick();
        chk("rst_release", SCW'({req_ready, busy}), SCW'(2'b10));

        for (int i = 0; i < 4; i++) begin
            run_job(vecs[i], $sformatf("v%0d", i));
        end

        // Reset asserted while draining the trigger pulse.
        model_mode = 0;
        req_pt = vecs[1].pt; req_key = vecs[1].key; req_reps = REP_W'(2); req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        wn = 0;
        while (!(aes_trigger && aes_enable) && wn < 100) begin tick(); wn++; end
        chk("mr_drain", SCW'(aes_trigger && aes_enable && busy), SCW'(1));
        rst_n = 1'b0;
        #1;
        chk("mr_flags", SCW'({req_ready, aes_enable, rsp_valid, rsp_last, rsp_timeout, busy}), SCW'(0));
        chk("mr_scan", aes_scan_chain, SCW'(0));
        chk("mr_rsp", SCW'({rsp_ct, rsp_idx}), SCW'(0));
        tick();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        chk("mr_no_rsp", SCW'(seen), SCW'(0));
        vj = mk(128'h0badf00d_0badf00d_0badf00d_0badf00d, 256'h2, 3'b111, 2, 0, 0,
                128'h13579bdf_2468ace0_13579bdf_2468ace0, 2, 1'b0);
        run_job(vj, "after_rst");

`ifdef AES_SEQ_TIMEOUT_EN
        vj = mk(128'h1, 256'h3, 3'b100, 3, 0, 1, 128'hffff0000_ffff0000_ffff0000_ffff0000, 1, 1'b1);
        run_job(vj, "wd_expire");
        vj = mk(128'h2, 256'h4, 3'b010, 1, 0, 3, 128'h00000000_11111111_22222222_33333333, 1, 1'b0);
        run_job(vj, "wd_race");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/aes_trace_seq.md
# aes_trace_seq

Request-driven sequencer that sits between the capture host logic and `aes_if`. It accepts one encryption job (plaintext, key, select bits, repetition count), packs and holds the 387-bit scan chain, and pulses `aes_enable` once per repetition. It edge-detects `aes_trigger`, captures the ciphertext from `aes_sc_out[127:0]`, and returns one response per repetition over a valid/ready channel. It replaces free-running bench stimulus with deterministic, back-pressured trace acquisition.

## Interface
- `SETTLE_CYCLES`, 2: clocks between scan-chain load and first `aes_enable` assertion; minimum 1.
- `REP_W`, 8: width of repetition count and index.
- `TIMEOUT_CYCLES`, 1024: watchdog limit in RUN; used only with `AES_SEQ_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: job request valid.
- `req_ready` out 1: sequencer can accept a job.
- `req_pt` in 128: plaintext.
- `req_key` in 256: key.
- `req_pt_sel`, `req_key_sel`, `req_ct_out_sel` in 1 each: aes_if select bits.
- `req_reps` in REP_W: encryptions to run; 0 is treated as 1.
- `aes_scan_chain` out 387: `{pt, key, pt_sel, key_sel, ct_out_sel}`, registered.
- `aes_enable` out 1: run enable to aes_if.
- `aes_trigger` in 1: aes_if trigger, synchronous to `clk`.
- `aes_sc_out` in 387: aes_if scan output; only bits [127:0] are used.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_ct` out 128: captured ciphertext.
- `rsp_idx` out REP_W: 0-based repetition index.
- `rsp_last` out 1: final response of the job.
- `rsp_timeout` out 1: response produced by the watchdog.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, SETTLE, RUN, DRAIN, RESP.
- IDLE: `req_ready`=1. On `req_valid & req_ready`:
  - register the scan chain fields and `reps_m1` = max(req_reps,1)-1;
  - clear `idx`;
  - go to SETTLE.
- SETTLE: count `SETTLE_CYCLES` clocks, then go to RUN.
- RUN: `aes_enable`=1.
  - Wait for trigger rise, defined as `aes_trigger & ~trig_q`, where `trig_q` is a 1-cycle registered copy.
  - On rise: capture `aes_sc_out[127:0]` into `rsp_ct`, then go to DRAIN.
  - A trigger already high on RUN entry is stale and is not counted.
- DRAIN: `aes_enable`=1. Wait for `aes_trigger` sampled low, then go to RESP.
- RESP: `aes_enable`=0, `rsp_valid`=1. `rsp_ct`, `rsp_idx`, `rsp_last`=(idx==reps_m1) and `rsp_timeout` stay stable until `rsp_ready`. On handshake:
  - if `rsp_last`, go to IDLE;
  - otherwise `idx`+1 and go to RUN. SETTLE is not repeated; the scan chain is unchanged.
- `aes_scan_chain` holds its value until the next accepted request, including across IDLE.
- Reset values: `req_ready`=0, `aes_enable`=0, `aes_scan_chain`=0, `rsp_valid`=0, `rsp_ct`=0, `rsp_idx`=0, `rsp_last`=0, `rsp_timeout`=0, `busy`=0, state=IDLE. `req_ready` rises on the first clock after `rst_n` deasserts.
- Reset asserted mid-job aborts immediately. No response is emitted for the aborted job.

## Timing
- Acceptance edge = T0. `aes_scan_chain` is valid from T0+1.
- `aes_enable` rises at T0+1+SETTLE_CYCLES.
- Trigger rise sampled at edge Tr: `rsp_ct` is loaded at Tr.
- Trigger low sampled at edge Tf: `rsp_valid` is high from Tf+1.
- `aes_enable` falls at the same edge `rsp_valid` rises. It re-rises the edge after a non-last handshake.
- `rsp_ready` held high gives zero bubble: the handshake completes in 1 cycle in RESP.
- `req_ready` re-asserts the edge after the last response handshake.

## Configuration
- `AES_SEQ_TIMEOUT_EN` defined:
  - A RUN cycle counter counts up; it clears on RUN entry.
  - When the count reaches `TIMEOUT_CYCLES` with no rise: go to RESP with `rsp_timeout`=1, `rsp_ct`=0, `rsp_last`=1, and the current `idx`. The job ends after that handshake.
  - If a trigger rise and expiry occur in the same cycle, the trigger wins.
- `AES_SEQ_TIMEOUT_EN` undefined: no counter; RUN waits indefinitely; `rsp_timeout` is tied to 0.

## Structure
- `aes_seq_pkg`:
  - state enum;
  - localparams `AES_PT_W`=128, `AES_KEY_W`=256, `AES_SC_W`=387;
  - scan-chain field offsets `SC_PT_LSB`=259, `SC_KEY_LSB`=3, `SC_PT_SEL`=2, `SC_KEY_SEL`=1, `SC_CT_SEL`=0.
- One sub-module, `aes_seq_wdog`: load/clear/expire cycle counter, instantiated only under `AES_SEQ_TIMEOUT_EN`.

## Test plan
- Basic single job:
  - Stimulus: reset, then request pt=00112233445566778899aabbccddeeff, key=0, pt_sel=1, key_sel=1, ct_out_sel=0, reps=1. The aes_if model pulses trigger 3 cycles high, 5 cycles after enable.
  - Required: scan chain = {pt, 0, 1'b1, 1'b1, 1'b0}; exactly one response with `rsp_ct`=1c060f4c9e7ea8d6ca961a2d64c05c18, `rsp_idx`=0, `rsp_last`=1.
- Repetitions:
  - Stimulus: reps=4 with `rsp_ready` stalled 6 cycles per response.
  - Required: indices 0..3, `rsp_last` only on 3, `aes_enable` low throughout every stall, exactly 4 enable pulses.
- reps=0 and stale trigger:
  - Stimulus: reps=0, with the trigger model held high when RUN is entered.
  - Required: exactly one response; capture occurs only after trigger falls and rises again.
- Reset mid-job:
  - Stimulus: assert `rst_n` during DRAIN.
  - Required: all outputs at reset values asynchronously; no `rsp_valid`; the next job completes normally.
- Watchdog (`AES_SEQ_TIMEOUT_EN`, TIMEOUT_CYCLES=16):
  - Stimulus: model never triggers.
  - Required: `rsp_timeout`=1, `rsp_ct`=0, `rsp_last`=1 after 16 RUN cycles.
  - Stimulus: trigger on cycle 16.
  - Required: normal capture, `rsp_timeout`=0.
- Latency check:
  - Stimulus: SETTLE_CYCLES=3.
  - Required: enable rises exactly 4 edges after the acceptance edge.
